// File: rtl/bram_cfg_pkg.sv
// ============================================================================
// Module   : bram_cfg_pkg
// Brief    : Shared types and defaults for BRAM configuration-chain blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_cfg_pkg;

    localparam int C_CHAIN_LEN = 81;
    localparam int C_WORD_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PUSH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bram_ccff_bitser.sv
// ============================================================================
// Module   : bram_ccff_bitser
// Brief    : Word serialiser for the config chain plus readback capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_ccff_bitser
    import bram_cfg_pkg::*;
#(
    parameter int WORD_W = C_WORD_W,
    parameter int CNT_W  = $clog2(C_WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_bits,
    input  logic              shift_en,
    input  logic              tail,
    output logic              head,
    output logic              last_bit,
    output logic [WORD_W-1:0] rb_data
);

    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_rb;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_bits;

    // Readback is cleared on load so bits beyond a short final word stay 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_rb   <= '0;
            r_cnt  <= '0;
            r_bits <= '0;
        end else if (load) begin
            r_word <= load_data;
            r_rb   <= '0;
            r_cnt  <= '0;
            r_bits <= load_bits;
        end else if (shift_en) begin
            r_word <= r_word >> 1;
            r_rb   <= r_rb | (WORD_W'(tail) << r_cnt);
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign head     = r_word[0];
    assign last_bit = (r_cnt == (r_bits - CNT_W'(1)));
    assign rb_data  = r_rb;

endmodule

`default_nettype wire

// File: rtl/bram_ccff_loader.sv
// ============================================================================
// Module   : bram_ccff_loader
// Brief    : Streams bitstream words into the BRAM mode config chain and
//            returns the displaced chain bits as readback words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_ccff_loader
    import bram_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = C_CHAIN_LEN,
    parameter int WORD_W    = C_WORD_W
) (
    input  logic              prog_clock,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int REM_W = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    state_t            r_state;
    state_t            w_next;
    logic [REM_W-1:0]  r_remaining;
    logic              r_run;
    logic              r_aborted;
    logic              w_take_abort;
    logic              w_load;
    logic              w_shift;
    logic              w_last_bit;
    logic              w_head;
    logic [CNT_W-1:0]  w_bits;

    // Holds the FSM in IDLE for one edge after reset release.
    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) r_run <= 1'b0;
        else               r_run <= 1'b1;
    end

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_aborted <= w_take_abort;
            if (r_state == ST_IDLE && w_next == ST_FETCH)
                r_remaining <= REM_W'(CHAIN_LEN);
            else if (w_shift)
                r_remaining <= r_remaining - REM_W'(1);
        end
    end

    assign w_bits = (int'(r_remaining) >= WORD_W) ? CNT_W'(WORD_W) : CNT_W'(r_remaining);

    // Abort outranks every other action, including the shift in its own cycle.
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        config_enable = 1'b0;
        w_take_abort  = abort && (r_state != ST_IDLE);
        if (w_take_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && r_run) w_next = ST_FETCH;
                end
                ST_FETCH: begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        w_load = 1'b1;
                        w_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    config_enable = 1'b1;
                    w_shift       = 1'b1;
                    if (w_last_bit) w_next = ST_PUSH;
                end
                ST_PUSH: begin
                    rd_valid = 1'b1;
                    if (rd_ready) w_next = (r_remaining == '0) ? ST_DONE : ST_FETCH;
                end
                ST_DONE: begin
                    w_next = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    bram_ccff_bitser #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_bitser (
        .clk       (prog_clock),
        .rst_n     (prog_reset_n),
        .load      (w_load),
        .load_data (wr_data),
        .load_bits (w_bits),
        .shift_en  (w_shift),
        .tail      (ccff_tail),
        .head      (w_head),
        .last_bit  (w_last_bit),
        .rb_data   (rd_data)
    );

    assign ccff_head = config_enable & w_head;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign aborted   = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_bram_ccff_loader.sv
// ============================================================================
// Module   : tb_bram_ccff_loader
// Brief    : Directed self-checking bench with a behavioural 81-bit chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_ccff_loader;

    localparam int CL = 81;
    localparam int W  = 32;

    logic          prog_clock   = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic          start        = 1'b0;
    logic          abort        = 1'b0;
    logic [W-1:0]  wr_data      = '0;
    logic          wr_valid     = 1'b0;
    logic          rd_ready     = 1'b0;
    logic          wr_ready;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          config_enable;
    logic          ccff_head;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          aborted;

    logic [CL-1:0] chain = '0;
    int            checks   = 0;
    int            failures = 0;

    always #5 prog_clock = ~prog_clock;

    // The configuration chain itself: bit shifted in first leaves at chain[0].
    always @(posedge prog_clock) begin
        if (config_enable) chain <= {ccff_head, chain[CL-1:1]};
    end
    assign ccff_tail = chain[0];

    bram_ccff_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (W)
    ) dut (
        .prog_clock    (prog_clock),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .abort         (abort),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .config_enable (config_enable),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clock);
        #1;
    endtask

    function automatic logic [38:0] outs();
        return {config_enable, ccff_head, wr_ready, rd_valid, busy, done, aborted, rd_data};
    endfunction

    // mode 0: no stalls, 1: wr/rd gaps, 2: extra start pulses while busy
    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                           input int mode, output logic [W-1:0] r0, output logic [W-1:0] r1,
                           output logic [W-1:0] r2, output int lat, output int en_cnt);
        logic [W-1:0] words [3];
        logic [W-1:0] rb [3];
        int widx;
        int ridx;
        int fcnt;
        int pcnt;
        words[0] = w0; words[1] = w1; words[2] = w2;
        rb[0] = '0; rb[1] = '0; rb[2] = '0;
        widx = 0; ridx = 0; fcnt = 0; pcnt = 0; lat = -1; en_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            wr_data  = words[(widx < 3) ? widx : 2];
            wr_valid = (mode != 1) || (fcnt >= 5);
            rd_ready = (mode != 1) || (pcnt >= 10);
            start    = (mode == 2) && (cyc == 10 || cyc == 88);
            #1;
            if (config_enable) en_cnt++;
            if (wr_ready) begin
                if (wr_valid) begin widx++; fcnt = 0; end
                else fcnt++;
            end
            if (rd_valid) begin
                if (rd_ready) begin
                    if (ridx < 3) rb[ridx] = rd_data;
                    ridx++;
                    pcnt = 0;
                end else pcnt++;
            end
            if (done) begin
                lat = cyc;
                break;
            end
            tick();
        end
        tick();
        start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        check_eq("done_one_cycle", {busy, done}, 2'b00);
        tick();
        #1;
        check_eq("stays_idle", busy, 1'b0);
        r0 = rb[0]; r1 = rb[1]; r2 = rb[2];
    endtask

    initial begin
        logic [W-1:0] r0, r1, r2;
        int lat, en, seen_done, seen_ab;

        tick();
        tick();
        check_eq("reset_outputs", outs(), '0);
        #2 prog_reset_n = 1'b1;
        tick(); tick(); tick();
        check_eq("idle_after_release", outs(), '0);

        // Load into an all-zero chain.
        do_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0001ABCD, 0, r0, r1, r2, lat, en);
        check_eq("l1_latency", lat, 88);
        check_eq("l1_enable_cycles", en, 81);
        check_eq("l1_readback", {r0, r1, r2}, 96'h0);
        check_eq("l1_chain", chain, {17'h1ABCD, 32'h0F0F0F0F, 32'hA5A5A5A5});

        // Readback returns the previous load.
        do_load(32'hFFFFFFFF, 32'h0, 32'h0, 0, r0, r1, r2, lat, en);
        check_eq("l2_latency", lat, 88);
        check_eq("l2_rb0", r0, 32'hA5A5A5A5);
        check_eq("l2_rb1", r1, 32'h0F0F0F0F);
        check_eq("l2_rb2", r2, 32'h0001ABCD);

        // Stalled handshakes: 3x5 write gaps + 3x10 read holds.
        do_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0001ABCD, 1, r0, r1, r2, lat, en);
        check_eq("l3_stall_latency", lat, 133);
        check_eq("l3_enable_cycles", en, 81);
        check_eq("l3_readback", {r0, r1, r2}, {32'hFFFFFFFF, 32'h0, 32'h0});
        check_eq("l3_chain", chain, {17'h1ABCD, 32'h0F0F0F0F, 32'hA5A5A5A5});

        // Start pulses during SHIFT and DONE are ignored.
        do_load(32'h12345678, 32'h9ABCDEF0, 32'h00000001, 2, r0, r1, r2, lat, en);
        check_eq("busy_start_latency", lat, 88);
        check_eq("busy_start_rb0", r0, 32'hA5A5A5A5);

        // Abort in the 40th shift cycle.
        en = 0; seen_done = 0; seen_ab = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'h5555AAAA;
            #1;
            if (done) seen_done = 1;
            if (config_enable) begin
                en++;
                if (en == 40) begin
                    abort = 1'b1;
                    break;
                end
            end
            tick();
        end
        check_eq("abort_reached_40", en, 40);
        tick();
        abort = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        check_eq("abort_next_cycle", {config_enable, aborted, busy, done}, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (aborted) seen_ab++;
            if (done) seen_done = 1;
        end
        check_eq("aborted_once_done_never", {seen_ab[3:0], seen_done[0]}, 5'b0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check_eq("idle_abort_no_pulse", {aborted, busy}, 2'b00);

        do_load(32'h0, 32'h0, 32'h0, 0, r0, r1, r2, lat, en);
        check_eq("after_abort_latency", lat, 88);
        check_eq("after_abort_enables", en, 81);

        // Reset asserted mid-SHIFT.
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_valid = 1'b1; rd_ready = 1'b1;
        for (int cyc = 1; cyc < 20; cyc++) tick();
        #1;
        check_eq("pre_reset_shifting", config_enable, 1'b1);
        prog_reset_n = 1'b0;
        #1;
        check_eq("reset_async_outputs", outs(), '0);
        tick();
        #1;
        check_eq("reset_hold_outputs", outs(), '0);
        wr_valid = 1'b0; rd_ready = 1'b0;
        #2 prog_reset_n = 1'b1;
        tick(); tick(); tick();
        check_eq("post_reset_idle", outs(), '0);

        do_load(32'hCAFEF00D, 32'h0, 32'h1, 0, r0, r1, r2, lat, en);
        check_eq("after_reset_latency", lat, 88);
        check_eq("after_reset_enables", en, 81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bram_ccff_loader.md
BRAM_CCFF_LOADER -- requirements
Module: bram_ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 81: length in bits of the BRAM mode configuration chain.
REQ-002 Parameter WORD_W, default 32: width of the bitstream words.
REQ-003 prog_clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 prog_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a load; ignored unless busy=0.
REQ-006 abort  input  1  terminates any load in progress.
REQ-007 wr_data  input  WORD_W  next bitstream word; bit 0 is shifted first.
REQ-008 wr_valid / wr_ready  input / output  1  bitstream handshake; a transfer occurs on a cycle where both are 1.
REQ-009 rd_data  output  WORD_W  readback word: the bits displaced from the chain.
REQ-010 rd_valid / rd_ready  output / input  1  readback handshake.
REQ-011 config_enable  output  1  chain shift enable.
REQ-012 ccff_head  output  1  serial data into the chain.
REQ-013 ccff_tail  input  1  serial data out of the chain.
REQ-014 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 aborted  output  1  one-cycle pulse when a load ends by abort.

Function
REQ-017 States: IDLE, FETCH, SHIFT, PUSH, DONE.
REQ-018 IDLE -> FETCH on start.
REQ-019 FETCH: wr_ready=1; on transfer, latch the word and go to SHIFT.
REQ-020 SHIFT: config_enable=1 for exactly k cycles, one bit per cycle; k = min(WORD_W, bits remaining).
REQ-021 During SHIFT, ccff_head carries latched bit j in the cycle j of the word.
REQ-022 ccff_tail is sampled on the same edge into readback bit j.
REQ-023 SHIFT -> PUSH after k bits.
REQ-024 PUSH: rd_valid=1 and rd_data stable until rd_ready.
REQ-025 PUSH exit: to FETCH if bits remain, else to DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 Readback bits at index >= k in the final word read as 0.
REQ-028 config_enable is 1 only in SHIFT; it totals exactly CHAIN_LEN cycles per completed load (81 → words of 32, 32, 17).
REQ-029 wr_ready=1 only in FETCH; rd_valid=1 only in PUSH.
REQ-030 Gaps in wr_valid or rd_ready stall the FSM in FETCH or PUSH with config_enable=0; chain contents are untouched during a stall.
REQ-031 Bits-remaining counter width = clog2(CHAIN_LEN+1); per-word counter width = clog2(WORD_W+1).
REQ-032 abort in any non-IDLE state → IDLE next cycle with config_enable=0 that cycle; aborted pulses; done is not asserted; the partial chain state is left as-is.
REQ-033 abort has priority over start, handshakes and shifting in the same cycle.
REQ-034 start while busy=1 is ignored.
REQ-035 abort in IDLE has no effect and does not pulse aborted.
REQ-036 Zero-stall latency: start at cycle T → done at cycle T + CHAIN_LEN + 2*ceil(CHAIN_LEN/WORD_W) + 1, which is T+88 for the defaults.

Reset
REQ-037 prog_reset_n=0 forces IDLE asynchronously.
REQ-038 During and after reset, all outputs are 0: config_enable, ccff_head, wr_ready, rd_valid, rd_data, busy, done, aborted.
REQ-039 Reset mid-SHIFT deasserts config_enable immediately (asynchronously) and produces no done/aborted pulse.
REQ-040 Release of reset is used synchronously; the first state change is on the second edge after release.

Structure
REQ-041 Package bram_cfg_pkg holds the state enum and the CHAIN_LEN/WORD_W defaults, shared with future BRAM configuration blocks.
REQ-042 One sub-module, bram_ccff_bitser, implements the latched word, the readback shift register and the per-word counter; the FSM and bits-remaining counter stay in the top level.

Verification
REQ-043 Chain model preloaded 0; load words 0xA5A5A5A5, 0x0F0F0F0F, 0x0001ABCD → done at T+88, config_enable high 81 cycles, all readback 0.
REQ-044 Repeat with words 0xFFFFFFFF, 0, 0 → readback = 0xA5A5A5A5, 0x0F0F0F0F, 0x0001ABCD.
REQ-045 Hold rd_ready=0 for 10 cycles at each PUSH and insert 5-cycle wr_valid gaps → done delayed by exactly 45 cycles; chain content identical to the no-stall case.
REQ-046 abort on the 40th SHIFT cycle → config_enable low next cycle, aborted=1 once, done never asserted, busy=0.
REQ-047 prog_reset_n low mid-SHIFT → all outputs 0 during reset.
REQ-048 start asserted during busy → ignored.
REQ-049 A fresh start after reset or abort completes normally.
